// File: rtl/fifo_tx.sv
// fifo_tx: SpaceWire transmit N-char buffer with FCT-driven credit tracking.
// N-chars leave through a registered valid/ready port only while remote credit remains.
module fifo_tx #(
  parameter int DWIDTH      = 9,
  parameter int AWIDTH      = 6,
  parameter int CREDIT_STEP = 8,
  parameter int CREDIT_MAX  = 56
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              fct_received,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DWIDTH-1:0] tx_data,
  output logic              f_full,
  output logic              f_empty,
  output logic [AWIDTH-1:0] credit_counter,
  output logic              credit_error,
  output logic [AWIDTH-1:0] counter
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH-1:0] FULL_COUNT   = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] CREDIT_LIMIT = AWIDTH'(CREDIT_MAX - CREDIT_STEP);
  localparam logic [AWIDTH-1:0] STEP         = AWIDTH'(CREDIT_STEP);
  localparam logic [AWIDTH-1:0] ONE          = AWIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  logic [DWIDTH-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] counter_q, counter_d;
  logic [AWIDTH-1:0] credit_q, credit_d;
  logic              credit_error_q, credit_error_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DWIDTH-1:0] tx_data_q, tx_data_d;

  logic wr_accept;
  logic consume;
  logic fct_legal;

  assign f_full    = (counter_q == FULL_COUNT);
  assign f_empty   = (counter_q == '0);
  assign wr_accept = wr_en && !f_full;
  assign consume   = (state_q == SEND) && tx_valid_q && tx_ready;
  // Legality is judged on the pre-edge credit, so a same-edge consume cannot make an FCT legal.
  assign fct_legal = (credit_q <= CREDIT_LIMIT);

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    rd_ptr_d   = rd_ptr_q;
    case (state_q)
      IDLE: begin
        if (counter_q != '0 && credit_q != '0) state_d = LOAD;
      end
      LOAD: begin
        tx_data_d  = mem[rd_ptr_q];
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (consume) begin
          rd_ptr_d   = rd_ptr_q + ONE;
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_accept ? (wr_ptr_q + ONE) : wr_ptr_q;
    case ({wr_accept, consume})
      2'b10:   counter_d = counter_q + ONE;
      2'b01:   counter_d = counter_q - ONE;
      default: counter_d = counter_q;
    endcase
    credit_d       = credit_q;
    credit_error_d = credit_error_q;
    if (fct_received) begin
      if (fct_legal) credit_d = credit_d + STEP;
      else           credit_error_d = 1'b1;
    end
    if (consume) credit_d = credit_d - ONE;
  end

  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      counter_q      <= '0;
      credit_q       <= '0;
      credit_error_q <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      counter_q      <= counter_d;
      credit_q       <= credit_d;
      credit_error_q <= credit_error_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
    end
  end

  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign counter        = counter_q;
  assign credit_counter = credit_q;
  assign credit_error   = credit_error_q;

endmodule

// File: tb/tb_fifo_tx.sv
// tb_fifo_tx: directed stimulus for fifo_tx, checked every cycle against a queue-based model
// of the buffer, the credit rules and the two-edge launch timing, plus hand-computed literals.
module tb_fifo_tx;

  localparam int DW = 9;
  localparam int AW = 6;

  logic          clock;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          fct_received;
  logic          tx_ready;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          f_full;
  logic          f_empty;
  logic [AW-1:0] credit_counter;
  logic          credit_error;
  logic [AW-1:0] counter;

  int total = 0;
  int bad   = 0;

  fifo_tx dut (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .data_in        (data_in),
    .fct_received   (fct_received),
    .tx_ready       (tx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .f_full         (f_full),
    .f_empty        (f_empty),
    .credit_counter (credit_counter),
    .credit_error   (credit_error),
    .counter        (counter)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: queue holds every stored char (including the one on offer), credit as an integer.
  logic [DW-1:0] mq[$];
  int            m_credit;
  int            m_consumed;
  bit            m_valid;
  bit            m_loading;
  bit            m_err;
  logic [DW-1:0] m_data;
  bit            m_take;
  bit            m_launch;
  bit            m_accept;
  bit            m_legal;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_credit   = 0;
      m_err      = 0;
      m_valid    = 0;
      m_loading  = 0;
      m_data     = '0;
    end else begin
      m_take   = m_valid && tx_ready;
      m_launch = !m_valid && !m_loading && mq.size() > 0 && m_credit > 0;
      m_accept = wr_en && mq.size() < 63;
      m_legal  = m_credit <= 48;
      if (m_take) begin
        void'(mq.pop_front());
        m_valid    = 0;
        m_consumed = m_consumed + 1;
      end else if (m_loading) begin
        m_data    = mq[0];
        m_valid   = 1;
        m_loading = 0;
      end else if (m_launch) begin
        m_loading = 1;
      end
      if (m_accept) mq.push_back(data_in);
      if (fct_received) begin
        if (m_legal) m_credit = m_credit + 8;
        else         m_err = 1;
      end
      if (m_take) m_credit = m_credit - 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    checkOutput("tx_valid", int'(tx_valid), int'(m_valid));
    checkOutput("counter", int'(counter), mq.size());
    checkOutput("credit_counter", int'(credit_counter), m_credit);
    checkOutput("credit_error", int'(credit_error), int'(m_err));
    checkOutput("f_full", int'(f_full), int'(mq.size() == 63));
    checkOutput("f_empty", int'(f_empty), int'(mq.size() == 0));
    if (m_valid) checkOutput("tx_data", int'(tx_data), int'(m_data));
  end

  task automatic applyStimulus(input logic wr, input logic [DW-1:0] din,
                               input logic fct, input logic rdy);
    wr_en        = wr;
    data_in      = din;
    fct_received = fct;
    tx_ready     = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, 1'b0, rdy);
  endtask

  task automatic doReset();
    wr_en = 0; data_in = '0; fct_received = 0; tx_ready = 0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic sendOne();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(2, 1'b0);
  endtask

  logic [DW-1:0] din;
  int            base;

  initial begin
    m_consumed = 0;
    doReset();
    checkOutput("reset f_empty", int'(f_empty), 1);
    checkOutput("reset tx_data", int'(tx_data), 0);

    $display("[TB] test 1: single char launch and handshake");
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 9'h0AB, 1'b0, 1'b0);
    checkOutput("t1 credit", int'(credit_counter), 8);
    checkOutput("t1 counter", int'(counter), 1);
    checkOutput("t1 valid early", int'(tx_valid), 0);
    idle(1, 1'b0);
    checkOutput("t1 valid one edge", int'(tx_valid), 0);
    idle(1, 1'b0);
    checkOutput("t1 valid two edges", int'(tx_valid), 1);
    checkOutput("t1 data", int'(tx_data), 'h0AB);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t1 credit after", int'(credit_counter), 7);
    checkOutput("t1 counter after", int'(counter), 0);
    checkOutput("t1 empty after", int'(f_empty), 1);

    $display("[TB] test 2: chars wait for credit");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 9'(9'h110 + i), 1'b0, 1'b0);
    idle(4, 1'b0);
    checkOutput("t2 valid no credit", int'(tx_valid), 0);
    checkOutput("t2 counter", int'(counter), 3);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    idle(15, 1'b1);
    checkOutput("t2 credit end", int'(credit_counter), 5);
    checkOutput("t2 counter end", int'(counter), 0);

    $display("[TB] test 3: fill past full, drain with FCTs");
    doReset();
    for (int i = 0; i < 70; i++) begin
      din = 9'((i * 37 + 5) % 512);
      applyStimulus(1'b1, din, 1'b0, 1'b0);
    end
    checkOutput("t3 counter full", int'(counter), 63);
    checkOutput("t3 f_full", int'(f_full), 1);
    base = m_consumed;
    for (int c = 0; c < 260; c++)
      applyStimulus(1'b0, '0, (c % 24 == 0) && (c < 192), 1'b1);
    checkOutput("t3 drained count", m_consumed - base, 63);
    checkOutput("t3 counter end", int'(counter), 0);
    checkOutput("t3 credit end", int'(credit_counter), 1);
    applyStimulus(1'b1, 9'h155, 1'b1, 1'b1);
    applyStimulus(1'b1, 9'h0AA, 1'b0, 1'b1);
    idle(10, 1'b1);
    checkOutput("t3 wrap credit", int'(credit_counter), 7);
    checkOutput("t3 wrap counter", int'(counter), 0);

    $display("[TB] test 4: credit overflow");
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t4 credit max", int'(credit_counter), 56);
    checkOutput("t4 no error", int'(credit_error), 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t4 error set", int'(credit_error), 1);
    checkOutput("t4 credit held", int'(credit_counter), 56);
    idle(5, 1'b0);
    checkOutput("t4 error sticky", int'(credit_error), 1);

    $display("[TB] test 5: stall, FCT with consume, write with consume");
    doReset();
    checkOutput("t5 error cleared", int'(credit_error), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 9'(9'h1A0 + i), 1'b0, 1'b0);
    checkOutput("t5 valid", int'(tx_valid), 1);
    checkOutput("t5 data first", int'(tx_data), 'h1A0);
    idle(10, 1'b0);
    checkOutput("t5 data stable", int'(tx_data), 'h1A0);
    for (int i = 0; i < 4; i++) sendOne();
    checkOutput("t5 credit 20", int'(credit_counter), 20);
    checkOutput("t5 valid before fct", int'(tx_valid), 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("t5 credit 27", int'(credit_counter), 27);
    idle(2, 1'b0);
    checkOutput("t5 counter before", int'(counter), 1);
    checkOutput("t5 valid before wr", int'(tx_valid), 1);
    applyStimulus(1'b1, 9'h1C7, 1'b0, 1'b1);
    checkOutput("t5 counter unchanged", int'(counter), 1);
    checkOutput("t5 credit 26", int'(credit_counter), 26);

    $display("[TB] test 6: asynchronous reset during SEND");
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 9'(9'h040 + i), 1'b0, 1'b0);
    idle(3, 1'b0);
    checkOutput("t6 counter 5", int'(counter), 5);
    checkOutput("t6 valid", int'(tx_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6 async valid", int'(tx_valid), 0);
    checkOutput("t6 async counter", int'(counter), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("t6 credit", int'(credit_counter), 0);
    checkOutput("t6 f_empty", int'(f_empty), 1);
    checkOutput("t6 f_full", int'(f_full), 0);
    checkOutput("t6 tx_data", int'(tx_data), 0);
    applyStimulus(1'b1, 9'h123, 1'b1, 1'b0);
    idle(1, 1'b0);
    checkOutput("t6 idle launch pending", int'(tx_valid), 0);
    idle(1, 1'b0);
    checkOutput("t6 relaunch", int'(tx_valid), 1);
    checkOutput("t6 relaunch data", int'(tx_data), 'h123);
    idle(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
